// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: pixel beats in, pooled pixels out.
// With MAXPOOL_ARGMAX_EN defined it also carries the per-channel window argmax.
interface maxpool2x2_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] input_data_0;
  logic [DATA_W-1:0] input_data_1;
  logic              input_valid;
  logic [DATA_W-1:0] output_data_0;
  logic [DATA_W-1:0] output_data_1;
  logic              output_valid;
  logic              frame_done;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]        argmax_0;
  logic [1:0]        argmax_1;

  modport master (
    output input_data_0, input_data_1, input_valid,
    input  output_data_0, output_data_1, output_valid, frame_done, argmax_0, argmax_1
  );
  modport slave (
    input  input_data_0, input_data_1, input_valid,
    output output_data_0, output_data_1, output_valid, frame_done, argmax_0, argmax_1
  );
`else
  modport master (
    output input_data_0, input_data_1, input_valid,
    input  output_data_0, output_data_1, output_valid, frame_done
  );
  modport slave (
    input  input_data_0, input_data_1, input_valid,
    output output_data_0, output_data_1, output_valid, frame_done
  );
`endif
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over two channels using a half-width line buffer.
// Optional MAXPOOL_ARGMAX_EN adds the winning window position per channel.
module maxpool2x2_stream #(
  parameter int DATA_W = 8,
  parameter int IN_W   = 6,
  parameter int IN_H   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  maxpool2x2_stream_if.slave bus
);
  localparam int CW       = $clog2(IN_W);
  localparam int RW       = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LB_D     = (IN_W + 1) / 2;
  localparam int LAST_COL = (IN_W % 2 == 1) ? IN_W - 2 : IN_W - 1;
  localparam int LAST_ROW = (IN_H % 2 == 1) ? IN_H - 2 : IN_H - 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-2:0]     lb_addr;
  logic              beat;
  logic              in_win;
  logic [DATA_W-1:0] in_px    [2];
  logic [DATA_W-1:0] hmax     [2];
  logic [DATA_W-1:0] lbuf     [2][LB_D];
  logic [DATA_W-1:0] pair_max [2];
  logic [DATA_W-1:0] win_max  [2];
  logic [DATA_W-1:0] out_px   [2];
  logic              valid_q;
  logic              done_q;
`ifdef MAXPOOL_ARGMAX_EN
  logic              hidx     [2];
  logic              lidx     [2][LB_D];
  logic              pair_idx [2];
  logic [1:0]        win_idx  [2];
  logic [1:0]        out_idx  [2];
`endif

  assign in_px[0] = bus.input_data_0;
  assign in_px[1] = bus.input_data_1;
  assign beat     = ena & bus.input_valid;
  assign lb_addr  = col[CW-1:1];
  // Trailing odd column/row is consumed by the counters but never pooled.
  assign in_win   = (col <= CW'(LAST_COL)) && (row <= RW'(LAST_ROW));

  // Strict greater-than keeps the earlier raster pixel on ties.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      pair_max[c] = (in_px[c] > hmax[c]) ? in_px[c] : hmax[c];
      win_max[c]  = lbuf[c][lb_addr];
`ifdef MAXPOOL_ARGMAX_EN
      pair_idx[c] = (in_px[c] > hmax[c]) ? 1'b1 : hidx[c];
      win_idx[c]  = {1'b0, lidx[c][lb_addr]};
`endif
      if (hmax[c] > win_max[c]) begin
        win_max[c] = hmax[c];
`ifdef MAXPOOL_ARGMAX_EN
        win_idx[c] = 2'd2;
`endif
      end
      if (in_px[c] > win_max[c]) begin
        win_max[c] = in_px[c];
`ifdef MAXPOOL_ARGMAX_EN
        win_idx[c] = 2'd3;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        hmax[c]   <= '0;
        out_px[c] <= '0;
        for (int i = 0; i < LB_D; i++) lbuf[c][i] <= '0;
`ifdef MAXPOOL_ARGMAX_EN
        hidx[c]    <= 1'b0;
        out_idx[c] <= 2'd0;
        for (int i = 0; i < LB_D; i++) lidx[c][i] <= 1'b0;
`endif
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (beat) begin
        if (col == CW'(IN_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IN_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (in_win) begin
          if (!col[0]) begin
            for (int c = 0; c < 2; c++) begin
              hmax[c] <= in_px[c];
`ifdef MAXPOOL_ARGMAX_EN
              hidx[c] <= 1'b0;
`endif
            end
          end else if (!row[0]) begin
            for (int c = 0; c < 2; c++) begin
              lbuf[c][lb_addr] <= pair_max[c];
`ifdef MAXPOOL_ARGMAX_EN
              lidx[c][lb_addr] <= pair_idx[c];
`endif
            end
          end else begin
            for (int c = 0; c < 2; c++) begin
              out_px[c] <= win_max[c];
`ifdef MAXPOOL_ARGMAX_EN
              out_idx[c] <= win_idx[c];
`endif
            end
            valid_q <= 1'b1;
            done_q  <= (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
          end
        end
      end
    end
  end

  assign bus.output_data_0 = out_px[0];
  assign bus.output_data_1 = out_px[1];
  assign bus.output_valid  = valid_q;
  assign bus.frame_done    = done_q;
`ifdef MAXPOOL_ARGMAX_EN
  assign bus.argmax_0      = out_idx[0];
  assign bus.argmax_1      = out_idx[1];
`endif
endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pool over the two-channel feature map produced by the ReLU stage.
- Sits between relu_layer and linear_layer, where it replaces the pass-through pooling stage.
- Consumes one pixel per channel per input_valid beat, in raster order (row-major, IN_W wide).
- Emits one pooled pixel per channel for each completed 2x2 window, using a half-width line buffer.

Parameters:
- DATA_W, 8, pixel width per channel (unsigned).
- IN_W, 6, input feature-map width in pixels.
- IN_H, 6, input feature-map height in pixels.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- ena  input  1  design enable; all state is held while low
- input_data_0  input  DATA_W  channel 0 pixel
- input_data_1  input  DATA_W  channel 1 pixel
- input_valid  input  1  single-cycle beat qualifier; gaps between beats are allowed
- output_data_0  output  DATA_W  channel 0 pooled max
- output_data_1  output  DATA_W  channel 1 pooled max
- output_valid  output  1  one-cycle pulse per pooled pixel
- frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame

Behaviour:
- Reset (async assert, sync release): col/row counters = 0; line buffer and horizontal-max registers = 0; all outputs = 0.
- A beat is accepted on a rising edge with ena=1 and input_valid=1. Nothing happens otherwise.
- With ena=0, all state holds, and output_valid and frame_done are driven 0 on the next edge.
- Counters: col counts 0..IN_W-1 and wraps to 0 with row+1. row counts 0..IN_H-1 and wraps to 0 after the final beat.
- Even row, even col: hmax_c <= in_c.
- Even row, odd col: lbuf_c[col>>1] <= max(hmax_c, in_c).
- Odd row, even col: hmax_c <= in_c.
- Odd row, odd col: output_data_c <= max(lbuf_c[col>>1], hmax_c, in_c), and output_valid <= 1.
- Latency: output_valid rises on the edge after the accepting edge of the window's bottom-right beat (1 cycle).
- output_data holds its last value when output_valid=0.
- frame_done <= 1 together with output_valid for the beat at row IN_H-1 (or IN_H-2 if IN_H is odd), col IN_W-1 (or IN_W-2 if IN_W is odd).
- Odd dimensions use floor behaviour: the trailing column and/or row is consumed (counters advance) but never pooled and never written to the line buffer.
- Comparisons are unsigned. Ties resolve to the earlier pixel in raster order, which only matters for the optional feature.
- Output count per frame: (IN_W/2)*(IN_H/2) per channel; 9 with the defaults.
- Back-to-back frames: the first beat after wrap is treated as row 0, col 0. Stale line-buffer contents are overwritten before being read, so no clear is needed.
- Asserting rst_n low mid-frame aborts the frame immediately. The next accepted beat after release is row 0, col 0.
- No backpressure: the downstream stage must accept every output_valid pulse.

Optional Feature:
- Macro: MAXPOOL_ARGMAX_EN.
- Defined: adds output ports argmax_0 and argmax_1 (2 bits each), registered alongside output_data.
  - Value is the position of the winning pixel within the window: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
  - Ties go to the lowest index.
  - Requires a 1-bit index stored per line-buffer entry and per hmax register.
  - argmax resets to 0.
- Undefined: the ports and index storage do not exist. Data outputs are identical in both builds.

Test Plan:
- Continuous 36-beat frame, ch0 = raster index 0..35, ch1 = 35-index. Required response:
  - ch0 outputs 7, 9, 11, 19, 21, 23, 31, 33, 35.
  - ch1 outputs 35, 33, 31, 23, 21, 19, 11, 9, 7.
  - 9 output_valid pulses; frame_done only with the 9th.
- Same frame with input_valid asserted every 3rd cycle and ena dropped for 4 cycles mid-row 3 -> identical output values. Each output_valid comes exactly 1 cycle after its bottom-right beat.
- Two frames back to back, with frame 2 = constant 200 on both channels -> frame 2 yields nine 200s and no residue from frame 1.
- rst_n pulsed low after 20 beats, then a full 36-beat frame with the test-1 pattern -> outputs exactly match test 1, and nothing is emitted for the aborted partial frame.
- Parameter sweep IN_W=5, IN_H=5, ch0 = raster index 0..24 -> outputs 6, 8, 16, 18. frame_done comes with the 4th output, and the counter wraps after beat 25.
- MAXPOOL_ARGMAX_EN defined, first window ch0 = (9, 9, 5, 3) -> output_data_0 = 9, argmax_0 = 0 (tie goes to top-left). Window (1, 2, 3, 4) -> 4 with argmax 3.
